id_ex_pipe: RTL

ID_EX_PIPE -- requirements
Module: id_ex_pipe

---
 rtl/id_ex_pipe.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use hazard detection, flush and hold handling.
// Latency: one clk edge from id_* to ex_*; stall_o is combinational from EX state and ID fields.
// Backpressure: hold_i freezes every ex_* register (flush remembered); stall_o freezes PC and IF/ID.
module id_ex_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [18:0] id_ctrl,
    input  logic        id_valid,
    input  logic [31:0] id_pc4,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [15:0] id_imm16,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [4:0]  id_shamt,
    input  logic [5:0]  id_funct,
    input  logic        hold_i,
    input  logic        flush_i,
    output logic [18:0] ex_ctrl,
    output logic        ex_valid,
    output logic [31:0] ex_pc4,
    output logic [31:0] ex_rs_data,
    output logic [31:0] ex_rt_data,
    output logic [15:0] ex_imm16,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_rd,
    output logic [4:0]  ex_shamt,
    output logic [5:0]  ex_funct,
    output logic [4:0]  ex_wr_addr,
    output logic        stall_o,
    output logic [15:0] bubble_cnt
);

    typedef struct packed {
        logic [18:0] ctrl;
        logic        valid;
        logic [31:0] pc4;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [15:0] imm16;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [4:0]  wr_addr;
    } ex_regs_t;

    localparam int CTRL_REGDST   = 12;
    localparam int CTRL_MEMREAD  = 11;
    localparam int CTRL_M2R_HI   = 9;
    localparam int CTRL_M2R_LO   = 8;
    localparam logic [18:0] BUBBLE_CTRL = 19'h1C000;
    localparam logic [15:0] CNT_MAX     = 16'hFFFF;

    // BranchOp=3'b111 marks a bubble as "never branch"; everything else zero.
    localparam ex_regs_t BUBBLE = '{ctrl: BUBBLE_CTRL, default: '0};

    ex_regs_t    ex_q, ex_d;
    logic        flush_pend_q, flush_pend_d;
    logic [15:0] bubble_cnt_q, bubble_cnt_d;
    logic        load_bubble_cnt;
    logic [4:0]  id_wr_addr;
    logic        rt_match;

    // Destination: rd for R-type, $ra for link-with-rt-format (jal), else rt.
    always_comb begin
        id_wr_addr = id_rt;
        if (id_ctrl[CTRL_REGDST]) begin
            id_wr_addr = id_rd;
        end else if (id_ctrl[CTRL_M2R_HI:CTRL_M2R_LO] == 2'b10) begin
            id_wr_addr = 5'd31;
        end
    end

    always_comb begin
        rt_match = (ex_q.rt != 5'd0) && ((ex_q.rt == id_rs) || (ex_q.rt == id_rt));
        stall_o  = ex_q.valid && ex_q.ctrl[CTRL_MEMREAD] && rt_match && id_valid && !hold_i;
    end

    always_comb begin
        ex_d            = ex_q;
        flush_pend_d    = flush_pend_q;
        load_bubble_cnt = 1'b0;
        if (hold_i) begin
            // A redirect seen while frozen must still kill the ID instruction later.
            flush_pend_d = flush_pend_q | flush_i;
        end else if (flush_i || flush_pend_q) begin
            ex_d            = BUBBLE;
            flush_pend_d    = 1'b0;
            load_bubble_cnt = 1'b1;
        end else if (stall_o) begin
            ex_d            = BUBBLE;
            load_bubble_cnt = 1'b1;
        end else if (!id_valid) begin
            ex_d = BUBBLE;
        end else begin
            ex_d.ctrl    = id_ctrl;
            ex_d.valid   = 1'b1;
            ex_d.pc4     = id_pc4;
            ex_d.rs_data = id_rs_data;
            ex_d.rt_data = id_rt_data;
            ex_d.imm16   = id_imm16;
            ex_d.rs      = id_rs;
            ex_d.rt      = id_rt;
            ex_d.rd      = id_rd;
            ex_d.shamt   = id_shamt;
            ex_d.funct   = id_funct;
            ex_d.wr_addr = id_wr_addr;
        end
    end

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (load_bubble_cnt && (bubble_cnt_q != CNT_MAX)) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q         <= BUBBLE;
            flush_pend_q <= 1'b0;
            bubble_cnt_q <= '0;
        end else begin
            ex_q         <= ex_d;
            flush_pend_q <= flush_pend_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign ex_ctrl    = ex_q.ctrl;
    assign ex_valid   = ex_q.valid;
    assign ex_pc4     = ex_q.pc4;
    assign ex_rs_data = ex_q.rs_data;
    assign ex_rt_data = ex_q.rt_data;
    assign ex_imm16   = ex_q.imm16;
    assign ex_rs      = ex_q.rs;
    assign ex_rt      = ex_q.rt;
    assign ex_rd      = ex_q.rd;
    assign ex_shamt   = ex_q.shamt;
    assign ex_funct   = ex_q.funct;
    assign ex_wr_addr = ex_q.wr_addr;
    assign bubble_cnt = bubble_cnt_q;

endmodule
